// File: rtl/array_rw_arbiter.sv
// Read/write arbiter in front of a single-port 256x20 array; clears the array after reset.
// Optional macro ARRAY_RW_ARB_HOLD_READ_EN keeps the last read response on r_resp_data.
module array_rw_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r_req_valid,
    output logic        r_req_ready,
    input  logic [7:0]  r_req_addr,
    output logic        r_resp_valid,
    output logic [19:0] r_resp_data,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic [7:0]  w_req_addr,
    input  logic [19:0] w_req_data,
    input  logic [9:0]  w_req_mask,
    output logic        sram_en,
    output logic        sram_wmode,
    output logic [7:0]  sram_addr,
    output logic [9:0]  sram_wmask,
    output logic [19:0] sram_wdata,
    input  logic [19:0] sram_rdata,
    output logic        init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_sweep;
    logic [3:0] r_starve;
    logic       w_run;
    logic       w_starved;
    logic       w_rd_acc;
    logic       w_wr_acc;

    assign w_run     = (r_state == ST_RUN);
    assign w_starved = (r_starve == LIM);

    // Writes have priority until a pending read has lost LIM times in a row.
    assign r_req_ready = w_run && (!w_req_valid || w_starved);
    assign w_req_ready = w_run && !(r_req_valid && w_starved);

    assign w_rd_acc  = r_req_valid && r_req_ready;
    assign w_wr_acc  = w_req_valid && w_req_ready;
    assign init_done = w_run;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and array command; idle cycles drive a quiet bus.
    always_comb begin
        w_state_nxt = r_state;
        sram_en     = 1'b0;
        sram_wmode  = 1'b0;
        sram_addr   = 8'h00;
        sram_wmask  = 10'h000;
        sram_wdata  = 20'h00000;
        unique case (r_state)
            ST_INIT: begin
                // Held off while reset is asserted so the sweep
                // starts cleanly at address 0 on release.
                if (!reset) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = r_sweep;
                    sram_wmask = 10'h3FF;
                    if (r_sweep == 8'hFF) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_wr_acc) begin
                    sram_en    = 1'b1;
                    sram_wmode = 1'b1;
                    sram_addr  = w_req_addr;
                    sram_wmask = w_req_mask;
                    sram_wdata = w_req_data;
                end else if (w_rd_acc) begin
                    sram_en   = 1'b1;
                    sram_addr = r_req_addr;
                end
            end
        endcase
    end

    // Clear-sweep address, advances once per INIT cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sweep <= 8'h00;
        end else if (r_state == ST_INIT) begin
            r_sweep <= r_sweep + 8'd1;
        end
    end

    // Count consecutive losses of a waiting read, saturating at LIM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_starve <= 4'd0;
        end else if (w_run) begin
            if (r_req_valid && !w_rd_acc) begin
                if (!w_starved) begin
                    r_starve <= r_starve + 4'd1;
                end
            end else begin
                r_starve <= 4'd0;
            end
        end
    end

    // Response strobe one cycle after an accepted read.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
        end else begin
            r_resp_valid <= w_rd_acc;
        end
    end

`ifdef ARRAY_RW_ARB_HOLD_READ_EN
    logic [19:0] r_resp_hold;

    // Capture each response so it stays visible until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_resp_hold <= 20'h00000;
        end else if (r_resp_valid) begin
            r_resp_hold <= sram_rdata;
        end
    end

    assign r_resp_data = r_resp_valid ? sram_rdata : r_resp_hold;
`else
    assign r_resp_data = r_resp_valid ? sram_rdata : 20'h00000;
`endif

endmodule

// File: tb/tb_array_rw_arbiter.sv
// Bench for array_rw_arbiter: behavioural array, reference memory model,
// directed scenarios plus randomized traffic.
module tb_array_rw_arbiter;

    localparam int LIM = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        r_req_valid;
    logic        r_req_ready;
    logic [7:0]  r_req_addr;
    logic        r_resp_valid;
    logic [19:0] r_resp_data;
    logic        w_req_valid;
    logic        w_req_ready;
    logic [7:0]  w_req_addr;
    logic [19:0] w_req_data;
    logic [9:0]  w_req_mask;
    logic        sram_en;
    logic        sram_wmode;
    logic [7:0]  sram_addr;
    logic [9:0]  sram_wmask;
    logic [19:0] sram_wdata;
    logic [19:0] sram_rdata;
    logic        init_done;

    int checks = 0;
    int errors = 0;

    array_rw_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clock(clock), .reset(reset),
        .r_req_valid(r_req_valid), .r_req_ready(r_req_ready),
        .r_req_addr(r_req_addr),
        .r_resp_valid(r_resp_valid), .r_resp_data(r_resp_data),
        .w_req_valid(w_req_valid), .w_req_ready(w_req_ready),
        .w_req_addr(w_req_addr), .w_req_data(w_req_data),
        .w_req_mask(w_req_mask),
        .sram_en(sram_en), .sram_wmode(sram_wmode),
        .sram_addr(sram_addr), .sram_wmask(sram_wmask),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .init_done(init_done)
    );

    always #5 clock = ~clock;

    function automatic logic [19:0] lanes(input logic [9:0] m);
        logic [19:0] r;
        for (int l = 0; l < 10; l++) r[2*l +: 2] = {2{m[l]}};
        return r;
    endfunction

    // Behavioural single-port array, filled with junk before the clear.
    logic [19:0] mem [256];
    logic [19:0] rdq = 20'h0;
    bit          mem_filled = 1'b0;
    assign sram_rdata = rdq;

    always @(posedge clock) begin
        if (!mem_filled) begin
            for (int i = 0; i < 256; i++) mem[i] <= 20'($urandom);
            mem_filled <= 1'b1;
        end else if (sram_en) begin
            if (sram_wmode)
                mem[sram_addr] <= (mem[sram_addr] & ~lanes(sram_wmask))
                                | (sram_wdata & lanes(sram_wmask));
            else
                rdq <= mem[sram_addr];
        end
    end

    // Reference model: memory contents, loss streak, pending response.
    logic [19:0] ref_mem [256];
    int          m_starve;
    bit          m_resp_v;
    logic [19:0] m_resp_d;
    logic [19:0] m_held;

    function automatic void model_reset();
        for (int i = 0; i < 256; i++) ref_mem[i] = 20'h0;
        m_starve = 0;
        m_resp_v = 1'b0;
        m_resp_d = 20'h0;
        m_held   = 20'h0;
    endfunction

    function automatic logic [19:0] exp_rdata();
        if (m_resp_v) return m_resp_d;
`ifdef ARRAY_RW_ARB_HOLD_READ_EN
        return m_held;
`else
        return 20'h0;
`endif
    endfunction

    function automatic void model_commit(input bit rv, input logic [7:0] ra,
                                         input bit wv, input logic [7:0] wa,
                                         input logic [19:0] wd,
                                         input logic [9:0] wm);
        bit rwin;
        bit wwin;
        rwin = rv && (!wv || m_starve == LIM);
        wwin = wv && !(rv && m_starve == LIM);
        if (m_resp_v) m_held = m_resp_d;
        m_resp_v = rwin;
        if (rwin) m_resp_d = ref_mem[ra];
        if (wwin) ref_mem[wa] = (ref_mem[wa] & ~lanes(wm)) | (wd & lanes(wm));
        m_starve = (rv && !rwin) ? m_starve + 1 : 0;
    endfunction

    task automatic drive(input bit rv, input logic [7:0] ra,
                         input bit wv, input logic [7:0] wa,
                         input logic [19:0] wd, input logic [9:0] wm);
        r_req_valid = rv;
        r_req_addr  = ra;
        w_req_valid = wv;
        w_req_addr  = wa;
        w_req_data  = wd;
        w_req_mask  = wm;
    endtask

    task automatic test_reset();
        drive(1'b1, 8'h01, 1'b1, 8'h02, 20'h12345, 10'h3FF);
        reset = 1'b1;
        #1;
        checks++;
        if ({init_done, r_req_ready, w_req_ready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 000",
                     {init_done, r_req_ready, w_req_ready});
        end
        checks++;
        if ({r_resp_valid, r_resp_data} !== 21'h0) begin
            errors++;
            $display("FAIL reset_resp got %h exp 0", {r_resp_valid, r_resp_data});
        end
        repeat (3) @(negedge clock);
    endtask

    // Entered at a negedge with reset high; releases it and follows the sweep.
    task automatic test_init();
        reset = 1'b0;
        for (int i = 0; i <= 256; i++) begin
            if (i < 256)
                drive(1'($urandom), 8'h0, 1'($urandom), 8'h0, 20'h0, 10'h0);
            else
                drive(1'b0, 8'h0, 1'b0, 8'h0, 20'h0, 10'h0);
            #1;
            if (i < 256) begin
                checks++;
                if ({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}
                    !== {1'b1, 1'b1, 8'(i), 10'h3FF, 20'h0}) begin
                    errors++;
                    $display("FAIL init_bus[%0d] got %h exp %h", i,
                             {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata},
                             {1'b1, 1'b1, 8'(i), 10'h3FF, 20'h0});
                end
                checks++;
                if ({init_done, r_req_ready, w_req_ready} !== 3'b000) begin
                    errors++;
                    $display("FAIL init_ctl[%0d] got %b exp 000", i,
                             {init_done, r_req_ready, w_req_ready});
                end
            end else begin
                checks++;
                if ({init_done, r_req_ready, w_req_ready, sram_en} !== 4'b1110) begin
                    errors++;
                    $display("FAIL init_done got %b exp 1110",
                             {init_done, r_req_ready, w_req_ready, sram_en});
                end
            end
            @(negedge clock);
        end
        model_reset();
    endtask

    task automatic test_directed();
        typedef struct packed {
            bit rv; logic [7:0] ra; bit wv; logic [7:0] wa;
            logic [19:0] wd; logic [9:0] wm;
        } stim_t;
        stim_t       s [15];
        logic [19:0] d0;
        logic [19:0] d1;
        logic [20:0] lit;
        bit          rwin;
        bit          wwin;
        d0 = 20'($urandom);
        d1 = 20'($urandom);
        for (int i = 0; i < 15; i++) s[i] = '0;
        s[0]  = '{1'b1, 8'h7F, 1'b0, 8'h00, 20'h0, 10'h0};
        s[2]  = '{1'b0, 8'h00, 1'b1, 8'h10, 20'hABCDE, 10'h3FF};
        s[3]  = '{1'b1, 8'h10, 1'b0, 8'h00, 20'h0, 10'h0};
        s[5]  = '{1'b0, 8'h00, 1'b1, 8'h20, 20'hFFFFF, 10'h001};
        s[6]  = '{1'b1, 8'h20, 1'b0, 8'h00, 20'h0, 10'h0};
        s[8]  = '{1'b0, 8'h00, 1'b1, 8'h30, d0, 10'h3FF};
        s[9]  = '{1'b0, 8'h00, 1'b1, 8'h31, d1, 10'h3FF};
        s[10] = '{1'b1, 8'h30, 1'b0, 8'h00, 20'h0, 10'h0};
        s[11] = '{1'b1, 8'h31, 1'b0, 8'h00, 20'h0, 10'h0};
        for (int i = 0; i < 15; i++) begin
            drive(s[i].rv, s[i].ra, s[i].wv, s[i].wa, s[i].wd, s[i].wm);
            #1;
            rwin = s[i].rv && (!s[i].wv || m_starve == LIM);
            wwin = s[i].wv && !(s[i].rv && m_starve == LIM);
            checks++;
            if ({r_resp_valid, r_resp_data} !== {m_resp_v, exp_rdata()}) begin
                errors++;
                $display("FAIL dir_resp[%0d] got %h exp %h", i,
                         {r_resp_valid, r_resp_data}, {m_resp_v, exp_rdata()});
            end
            checks++;
            if ({sram_en, sram_wmode} !== {rwin | wwin, wwin}) begin
                errors++;
                $display("FAIL dir_cmd[%0d] got %b exp %b", i,
                         {sram_en, sram_wmode}, {rwin | wwin, wwin});
            end
            lit = 21'h1FFFFF;
            case (i)
                1:  lit = {1'b1, 20'h00000};
                4:  lit = {1'b1, 20'hABCDE};
                7:  lit = {1'b1, 20'h00003};
                11: lit = {1'b1, d0};
                12: lit = {1'b1, d1};
`ifdef ARRAY_RW_ARB_HOLD_READ_EN
                13: lit = {1'b0, d1};
`else
                13: lit = {1'b0, 20'h00000};
`endif
                default: ;
            endcase
            if (lit != 21'h1FFFFF) begin
                checks++;
                if ({r_resp_valid, r_resp_data} !== lit) begin
                    errors++;
                    $display("FAIL dir_value[%0d] got %h exp %h", i,
                             {r_resp_valid, r_resp_data}, lit);
                end
            end
            model_commit(s[i].rv, s[i].ra, s[i].wv, s[i].wa, s[i].wd, s[i].wm);
            @(negedge clock);
        end
    endtask

    task automatic test_starve();
        logic [19:0] d;
        bit          win;
        for (int i = 0; i < 20; i++) begin
            d = 20'($urandom);
            drive(1'b1, 8'h7F, 1'b1, 8'h90, d, 10'h3FF);
            #1;
            win = (i % (LIM + 1)) == LIM;
            checks++;
            if ({r_req_ready, w_req_ready, sram_wmode} !== {win, !win, !win}) begin
                errors++;
                $display("FAIL starve_grant[%0d] got %b exp %b", i,
                         {r_req_ready, w_req_ready, sram_wmode}, {win, !win, !win});
            end
            checks++;
            if (r_resp_valid !== (i > 0 && (i % (LIM + 1)) == 0)) begin
                errors++;
                $display("FAIL starve_resp[%0d] got %b", i, r_resp_valid);
            end
            model_commit(1'b1, 8'h7F, 1'b1, 8'h90, d, 10'h3FF);
            @(negedge clock);
        end
        drive(1'b0, 8'h0, 1'b0, 8'h0, 20'h0, 10'h0);
        #1;
        checks++;
        if ({r_resp_valid, r_resp_data} !== {1'b1, 20'h0}) begin
            errors++;
            $display("FAIL starve_last got %h exp %h",
                     {r_resp_valid, r_resp_data}, {1'b1, 20'h0});
        end
        model_commit(1'b0, 8'h0, 1'b0, 8'h0, 20'h0, 10'h0);
        @(negedge clock);
    endtask

    task automatic test_random();
        bit          rv;
        bit          wv;
        logic [7:0]  ra;
        logic [7:0]  wa;
        logic [19:0] wd;
        logic [9:0]  wm;
        bit          e_rr;
        bit          e_wr;
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 9) < 6);
            wv = ($urandom_range(0, 9) < 7);
            ra = 8'h40 + 8'($urandom_range(0, 7));
            wa = 8'h40 + 8'($urandom_range(0, 7));
            wd = 20'($urandom);
            wm = 10'($urandom);
            drive(rv, ra, wv, wa, wd, wm);
            #1;
            e_rr = !wv || m_starve == LIM;
            e_wr = !(rv && m_starve == LIM);
            checks++;
            if ({r_req_ready, w_req_ready} !== {e_rr, e_wr}) begin
                errors++;
                $display("FAIL rnd_ready[%0d] got %b exp %b", i,
                         {r_req_ready, w_req_ready}, {e_rr, e_wr});
            end
            checks++;
            if ({r_resp_valid, r_resp_data} !== {m_resp_v, exp_rdata()}) begin
                errors++;
                $display("FAIL rnd_resp[%0d] got %h exp %h", i,
                         {r_resp_valid, r_resp_data}, {m_resp_v, exp_rdata()});
            end
            checks++;
            if (wv && e_wr) begin
                if ({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}
                    !== {1'b1, 1'b1, wa, wm, wd}) begin
                    errors++;
                    $display("FAIL rnd_wr[%0d] got %h exp %h", i,
                             {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata},
                             {1'b1, 1'b1, wa, wm, wd});
                end
            end else if (rv && e_rr) begin
                if ({sram_en, sram_wmode, sram_addr} !== {1'b1, 1'b0, ra}) begin
                    errors++;
                    $display("FAIL rnd_rd[%0d] got %h exp %h", i,
                             {sram_en, sram_wmode, sram_addr}, {1'b1, 1'b0, ra});
                end
            end else begin
                if ({sram_en, sram_wmode, sram_wmask, sram_wdata} !== 32'h0) begin
                    errors++;
                    $display("FAIL rnd_idle[%0d] got %h exp 0", i,
                             {sram_en, sram_wmode, sram_wmask, sram_wdata});
                end
            end
            model_commit(rv, ra, wv, wa, wd, wm);
            @(negedge clock);
        end
        drive(1'b0, 8'h0, 1'b0, 8'h0, 20'h0, 10'h0);
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 8'h10, 1'b0, 8'h0, 20'h0, 10'h0);
        #1;
        checks++;
        if (r_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_flight_accept got %b exp 1", r_req_ready);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        drive(1'b0, 8'h0, 1'b0, 8'h0, 20'h0, 10'h0);
        #1;
        checks++;
        if ({r_resp_valid, r_resp_data, init_done, r_req_ready, w_req_ready}
            !== 24'h0) begin
            errors++;
            $display("FAIL rst_flight got %h exp 0",
                     {r_resp_valid, r_resp_data, init_done, r_req_ready, w_req_ready});
        end
        @(negedge clock);
        #1;
        checks++;
        if ({r_resp_valid, init_done} !== 2'b00) begin
            errors++;
            $display("FAIL rst_flight_hold got %b exp 00", {r_resp_valid, init_done});
        end
        @(negedge clock);
        test_init();
        drive(1'b1, 8'h10, 1'b0, 8'h0, 20'h0, 10'h0);
        @(negedge clock);
        drive(1'b0, 8'h0, 1'b0, 8'h0, 20'h0, 10'h0);
        #1;
        checks++;
        if ({r_resp_valid, r_resp_data} !== {1'b1, 20'h0}) begin
            errors++;
            $display("FAIL rst_reclear got %h exp %h",
                     {r_resp_valid, r_resp_data}, {1'b1, 20'h0});
        end
        @(negedge clock);
    endtask

    initial begin
        drive(1'b0, 8'h0, 1'b0, 8'h0, 20'h0, 10'h0);
        #2;
        test_reset();
        test_init();
        test_directed();
        test_starve();
        test_random();
        test_reset_inflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/array_rw_arbiter.md
ARRAY_RW_ARBITER -- requirements
Module: array_rw_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive cycles a valid read may lose to writes (range 1..15).
REQ-002 SHALL have ports clock input 1, rising-edge clock; reset input 1, asynchronous active-high reset.
REQ-003 SHALL have r_req_valid input 1, r_req_ready output 1, r_req_addr input 8: read request channel.
REQ-004 SHALL have r_resp_valid output 1, r_resp_data output 20: read response.
REQ-005 SHALL have w_req_valid input 1, w_req_ready output 1, w_req_addr input 8, w_req_data input 20, w_req_mask input 10 (one bit per 2-bit lane): write channel.
REQ-006 SHALL have sram_en, sram_wmode output 1 each; sram_addr output 8; sram_wmask output 10; sram_wdata output 20; sram_rdata input 20: single-port 256x20 array, read data one cycle after read enable.
REQ-007 SHALL have init_done output 1: high once array clear completes.

Function
REQ-008 SHALL implement FSM states INIT and RUN; INIT entered on reset.
REQ-009 In INIT: one write per cycle, sram_en=1, sram_wmode=1, sram_wmask=10'h3FF, sram_wdata=0, sram_addr = sweep counter 0..255; both readies low.
REQ-010 After writing address 255: next cycle state RUN, init_done=1 (stays 1 until reset).
REQ-011 In RUN, handshake fires when valid&&ready; at most one request reaches the array per cycle.
REQ-012 Writes win over reads unless starve counter == STARVE_LIMIT, then read wins.
REQ-013 w_req_ready = RUN && !(r_req_valid && starve==STARVE_LIMIT); r_req_ready = RUN && (!w_req_valid || starve==STARVE_LIMIT); both combinational, no dependence on ready-to-valid.
REQ-014 Starve counter (4 bit): +1 each RUN cycle r_req_valid high and read not accepted; cleared when read accepted or r_req_valid low; never exceeds STARVE_LIMIT.
REQ-015 Accepted write: same cycle sram_en=1, sram_wmode=1, address/data/mask passed through unmodified.
REQ-016 Accepted read in cycle T: sram_en=1, sram_wmode=0 in T; r_resp_valid=1 and r_resp_data=sram_rdata in T+1; no backpressure on response.
REQ-017 No request accepted: sram_en=0; sram_wmode, sram_wmask, sram_wdata driven 0.
REQ-018 Write at cycle T, read same address at T+1: response returns written lanes (array ordering, no forwarding logic).
REQ-019 Back-to-back reads SHALL sustain one per cycle, responses in order.

Reset
REQ-020 Asserting reset (any time, incl. mid-INIT or with a read in flight) SHALL immediately force: state INIT, sweep counter 0, starve counter 0, init_done=0, r_resp_valid=0, r_resp_data=0, readies low; in-flight response discarded.
REQ-021 Array clear SHALL restart from address 0 on the first clock edge after reset deasserts.

Configuration
REQ-022 Macro ARRAY_RW_ARB_HOLD_READ_EN: defined -> r_resp_data registers the sampled sram_rdata at each response and holds it until the next response; undefined -> r_resp_data equals sram_rdata when r_resp_valid=1, else 0, with no data register.

Verification
REQ-023 Reset then idle 260 cycles -> 256 clear writes addr 0..255 mask 3FF data 0; init_done rises cycle 257; read addr 0x7F returns 20'h0.
REQ-024 Write addr 0x10 data 20'hABCDE mask 10'h3FF, then read 0x10 -> r_resp_valid one cycle after accept, data 20'hABCDE.
REQ-025 Mask: write 0x20 data 20'hFFFFF mask 10'h001 over cleared array -> read returns 20'h00003.
REQ-026 Continuous w_req_valid and r_req_valid, STARVE_LIMIT=4 -> pattern 4 writes, 1 read, repeating; counter never exceeds 4.
REQ-027 Reset asserted cycle after read accept -> r_resp_valid stays 0, init_done falls, clear sweep restarts at address 0.
REQ-028 Two reads then idle, with and without ARRAY_RW_ARB_HOLD_READ_EN -> held data persists vs r_resp_data returns to 0 after the response.
